// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8: 8-requester round-robin arbiter with a valid/ready handshake
// that drives the select of an 8-to-1 32-bit selector.
// Optional burst locking is built in when ARB_LOCK_EN is defined.
module rr_arbiter_8 (
  input  logic       Clock,
  input  logic       Reset_n,
  input  logic [7:0] Request,
  input  logic       Grant_Ready,
`ifdef ARB_LOCK_EN
  input  logic       Lock,
`endif
  output logic [2:0] Select_Output,
  output logic [7:0] Grant,
  output logic       Grant_Valid
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] sel_q, sel_d;
  logic [7:0] grant_q, grant_d;
  logic       valid_q, valid_d;
  logic       sync_q;

  logic [2:0] ptr_next;
  logic [3:0] pick_idle;
  logic [3:0] pick_hs;
  logic       lock_hold;

  // Returns {found, index} of the first set request scanning base, base+1, ... wrapping.
  // Iterating from the farthest offset down lets the nearest match win.
  function automatic logic [3:0] rr_pick(input logic [7:0] req, input logic [2:0] base);
    logic [3:0] res;
    logic [2:0] idx;
    res = '0;
    for (int unsigned i = 8; i > 0; i--) begin
      idx = base + 3'(i - 1);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // Arbitration candidates: from the current pointer (IDLE) and from the post-handshake pointer
  always_comb begin
    ptr_next  = sel_q + 3'd1;
    pick_idle = rr_pick(Request, ptr_q);
    pick_hs   = rr_pick(Request, ptr_next);
`ifdef ARB_LOCK_EN
    lock_hold = Lock && Request[sel_q];
`else
    lock_hold = 1'b0;
`endif
  end

  // Next-state and registered-output computation
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    grant_d = grant_q;
    valid_d = valid_q;
    unique case (state_q)
      IDLE: begin
        // Arbitration waits for one synchronising edge after reset release
        if (sync_q && pick_idle[3]) begin
          state_d = GRANT;
          sel_d   = pick_idle[2:0];
          grant_d = 8'd1 << pick_idle[2:0];
          valid_d = 1'b1;
        end
      end
      GRANT: begin
        if (Grant_Ready && !lock_hold) begin
          ptr_d = ptr_next;
          if (pick_hs[3]) begin
            sel_d   = pick_hs[2:0];
            grant_d = 8'd1 << pick_hs[2:0];
          end else begin
            state_d = IDLE;
            grant_d = '0;
            valid_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  // State, pointer and output registers with asynchronous reset
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      grant_q <= '0;
      valid_q <= 1'b0;
      sync_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      sync_q  <= 1'b1;
    end
  end

  assign Select_Output = sel_q;
  assign Grant         = grant_q;
  assign Grant_Valid   = valid_q;

endmodule
